// File: rtl/alu_exec_if.sv
// Request/response bundle between an ALU issue stage and the alu_exec unit.
// The issuing side uses the master modport; the execute unit uses slave.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, aluctl, a, b, c, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, aluctl, a, b, c, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith ops plus an iterative
// modular shift-add multiply-accumulate, (a*b + c) mod MODULUS.
module alu_exec #(
    parameter int WIDTH   = 32,
    parameter int MODULUS = 65521
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

    localparam logic [3:0] OP_AND       = 4'd0;
    localparam logic [3:0] OP_OR        = 4'd1;
    localparam logic [3:0] OP_ADD       = 4'd2;
    localparam logic [3:0] OP_DXOR      = 4'd5;
    localparam logic [3:0] OP_SUB       = 4'd6;
    localparam logic [3:0] OP_SLT       = 4'd7;
    localparam logic [3:0] OP_ANDOR     = 4'd8;
    localparam logic [3:0] OP_MULADDMOD = 4'd10;
    localparam logic [3:0] OP_NOR       = 4'd12;
    localparam logic [3:0] OP_XOR       = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_bit;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_fin_sum;
    logic [WIDTH-1:0] w_fin;
    logic             w_accept;

    // Operands are always below 2*MODULUS here, so one conditional subtract reduces fully.
    function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] v);
        mod_reduce = (v >= MOD_EXT) ? WIDTH'(v - MOD_EXT) : WIDTH'(v);
    endfunction

    assign w_accept  = (r_state == ST_IDLE) && bus.in_valid;
    assign w_sum     = bus.a + bus.b;
    assign w_diff    = bus.a - bus.b;
    assign w_slt     = ($signed(bus.a) < $signed(bus.b));

    assign w_dbl     = mod_reduce({r_acc, 1'b0});
    assign w_addend  = r_b[r_bit] ? r_a : {WIDTH{1'b0}};
    assign w_add     = {1'b0, w_dbl} + {1'b0, w_addend};
    assign w_step    = mod_reduce(w_add);
    assign w_fin_sum = {1'b0, r_acc} + {1'b0, r_c};
    assign w_fin     = mod_reduce(w_fin_sum);

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;

    // Single-cycle result and overflow, evaluated from the live request at accept.
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        w_alu_ovf = 1'b0;
        case (bus.aluctl)
            OP_AND:   w_alu_res = bus.a & bus.b;
            OP_OR:    w_alu_res = bus.a | bus.b;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_NOR:   w_alu_res = ~(bus.a | bus.b);
            OP_XOR:   w_alu_res = bus.a ^ bus.b;
            OP_DXOR:  w_alu_res = bus.a ^ bus.b ^ bus.c;
            OP_ANDOR: w_alu_res = (bus.a & bus.b) | bus.c;
            default: begin
                w_alu_res = {WIDTH{1'b0}};
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.aluctl == OP_MULADDMOD) begin
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_bit == {CW{1'b0}}) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end
            ST_FIN:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, multiply iteration and registered result/flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_c      <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_bit    <= {CW{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_c   <= bus.c;
                        r_acc <= {WIDTH{1'b0}};
                        r_bit <= CW'(WIDTH - 1);
                        if (bus.aluctl != OP_MULADDMOD) begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == {WIDTH{1'b0}});
                            r_ovf    <= w_alu_ovf;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc <= w_step;
                    r_bit <= r_bit - CW'(1);
                end
                ST_FIN: begin
                    r_result <= w_fin;
                    r_zero   <= (w_fin == {WIDTH{1'b0}});
                    r_ovf    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec with hand-written sequences for
// reset, backpressure and reset-during-multiply.
module tb_alu_exec;
    localparam int W = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] res;
        logic        z;
        logic        ov;
        int          lat;
    } vec_t;

    localparam int NV = 18;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    vec_t        vecs[NV];
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          lat;
    bit          busy_ok;
    bit          saw_valid;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec #(.WIDTH(W), .MODULUS(65521)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after the result was seen.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, output logic [31:0] r, output logic zf,
                          output logic of, output int l, output bit busy);
        int guard;
        busy  = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.aluctl   = op;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.aluctl   = 4'd0;
        bus.a        = 32'hDEADBEEF;
        bus.b        = 32'h12345678;
        bus.c        = 32'hCAFEF00D;
        @(negedge clk);
        l = 1;
        while (!bus.out_valid && l < 100) begin
            if (bus.in_ready) busy = 1'b0;
            @(negedge clk);
            l++;
        end
        r  = bus.result;
        zf = bus.zero;
        of = bus.overflow;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.aluctl    = 4'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.c         = 32'd0;

        vecs[0]  = '{4'd2,  32'd3,          32'd4,          32'd0,          32'd7,          1'b0, 1'b0, 1};
        vecs[1]  = '{4'd2,  32'h7FFFFFFF,   32'd1,          32'd0,          32'h80000000,   1'b0, 1'b1, 1};
        vecs[2]  = '{4'd6,  32'd5,          32'd7,          32'd0,          32'hFFFFFFFE,   1'b0, 1'b0, 1};
        vecs[3]  = '{4'd6,  32'd9,          32'd9,          32'd0,          32'd0,          1'b1, 1'b0, 1};
        vecs[4]  = '{4'd7,  32'hFFFFFFFF,   32'd1,          32'd0,          32'd1,          1'b0, 1'b0, 1};
        vecs[5]  = '{4'd5,  32'hF0F0F0F0,   32'h0FF00FF0,   32'h00000001,   32'hFF00FF01,   1'b0, 1'b0, 1};
        vecs[6]  = '{4'd8,  32'h0000FF00,   32'h00000F0F,   32'h00000001,   32'h00000F01,   1'b0, 1'b0, 1};
        vecs[7]  = '{4'd12, 32'd0,          32'd0,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0, 1};
        vecs[8]  = '{4'd15, 32'd5,          32'd6,          32'd7,          32'd0,          1'b1, 1'b0, 1};
        vecs[9]  = '{4'd0,  32'hF0F0F0F0,   32'hFF00FF00,   32'd0,          32'hF000F000,   1'b0, 1'b0, 1};
        vecs[10] = '{4'd1,  32'h0F0F0000,   32'h000000F0,   32'd0,          32'h0F0F00F0,   1'b0, 1'b0, 1};
        vecs[11] = '{4'd13, 32'hAAAA5555,   32'hFFFF0000,   32'd0,          32'h55555555,   1'b0, 1'b0, 1};
        vecs[12] = '{4'd6,  32'h80000000,   32'd1,          32'd0,          32'h7FFFFFFF,   1'b0, 1'b1, 1};
        vecs[13] = '{4'd7,  32'd1,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b1, 1'b0, 1};
        vecs[14] = '{4'd3,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd0,          1'b1, 1'b0, 1};
        vecs[15] = '{4'd10, 32'd1000,       32'd70000,      32'd5,          32'd23577,      1'b0, 1'b0, 34};
        vecs[16] = '{4'd10, 32'd2,          32'd3,          32'd65520,      32'd5,          1'b0, 1'b0, 34};
        vecs[17] = '{4'd10, 32'd0,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b1, 1'b0, 34};

        // Reset values, while held and after release
        repeat (2) @(negedge clk);
        chk("rst in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst result",    bus.result,             32'd0);
        chk("rst zero",      {31'd0, bus.zero},      32'd0);
        chk("rst overflow",  {31'd0, bus.overflow},  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Park a result in DONE, then reset asynchronously between edges
        bus.out_ready = 1'b0;
        run_op(4'd12, 32'd0, 32'd0, 32'd0, res, z, ov, lat, busy_ok);
        chk("held nor result", res, 32'hFFFFFFFF);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async rst result",    bus.result,             32'd0);
        chk("async rst in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, res, z, ov, lat, busy_ok);
            chk($sformatf("v%0d result", i),   res,               vecs[i].res);
            chk($sformatf("v%0d zero", i),     {31'd0, z},        {31'd0, vecs[i].z});
            chk($sformatf("v%0d overflow", i), {31'd0, ov},       {31'd0, vecs[i].ov});
            chk($sformatf("v%0d latency", i),  32'(lat),          32'(vecs[i].lat));
            if (vecs[i].lat > 1) begin
                chk($sformatf("v%0d in_ready low while busy", i), {31'd0, busy_ok}, 32'd1);
            end
            chk($sformatf("v%0d out_valid after transfer", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure: result held, new requests ignored
        bus.out_ready = 1'b0;
        run_op(4'd2, 32'd10, 32'd20, 32'd0, res, z, ov, lat, busy_ok);
        chk("bp first result", res, 32'd30);
        for (int k = 0; k < 10; k++) begin
            bus.aluctl   = 4'd6;
            bus.a        = 32'd1;
            bus.b        = 32'd1;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp%0d result", k),    bus.result,             32'd30);
            chk($sformatf("bp%0d out_valid", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp%0d in_ready", k),  {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp transfer out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp result kept",        bus.result,             32'd30);
        chk("bp in_ready back",      {31'd0, bus.in_ready},  32'd1);
        run_op(4'd6, 32'd100, 32'd1, 32'd0, res, z, ov, lat, busy_ok);
        chk("bp next op result", res, 32'd99);
        chk("bp next op latency", 32'(lat), 32'd1);

        // Reset during the multiply iteration
        saw_valid    = 1'b0;
        bus.aluctl   = 4'd10;
        bus.a        = 32'd1000;
        bus.b        = 32'd70000;
        bus.c        = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        reset = 1'b1;
        #1;
        chk("mul rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("mul rst no out_valid", {31'd0, saw_valid}, 32'd0);
        chk("mul rst result",       bus.result,         32'd0);
        run_op(4'd10, 32'd2, 32'd3, 32'd65520, res, z, ov, lat, busy_ok);
        chk("post rst mul result",  res,      32'd5);
        chk("post rst mul latency", 32'(lat), 32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Multi-cycle ALU execute unit at the consuming end of the 4-bit aluctl control code produced by the ALU control decoder.
- Takes aluctl plus three operands (a, b, c) through a valid/ready handshake and returns a registered result with zero and overflow flags.
- Single-cycle ops finish in one cycle.
- muladdmod runs an iterative modular shift-add multiply for the virus-signature hashing path.

Parameters:
WIDTH, 32, operand/result width in bits
MODULUS, 65521, modulus for muladdmod; must satisfy 2 <= MODULUS < 2^(WIDTH-1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
aluctl  input  4  operation code
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c  input  WIDTH  operand C (double xor, andor, muladdmod)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow (add/sub only, else 0)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0. Internal acc, bit counter and latched operands cleared.
- Reset mid-operation aborts the op, with no output.
- FSM states: IDLE, MUL, FIN, DONE.
- in_ready = (state==IDLE), combinational from state.
- Request accepted on a clk edge with in_valid && in_ready. Operands and aluctl are latched at that edge.
- Op codes, single-cycle: 0 and; 1 or; 2 add; 6 sub (a-b); 7 slt (signed a<b ? 1 : 0); 12 nor; 13 xor; 5 double xor a^b^c; 8 andor (a&b)|c. Any other code gives result 0 with zero=1.
- Single-cycle path: IDLE -> DONE at the accept edge. result, zero and overflow are registered at that edge, so out_valid=1 the next cycle (latency 1).
- overflow, add: a and b have the same sign and the result sign differs. Sub: a and b signs differ and the result sign differs from a. overflow=0 for all other ops.
- muladdmod (10) computes (a*b + c) mod MODULUS. Precondition: a < MODULUS and c < MODULUS; otherwise result is unspecified. b is unrestricted.
- At accept: acc=0, bit index = WIDTH-1, state -> MUL.
- MUL step, one per cycle, b scanned MSB first:
  - t = 2*acc, minus MODULUS if t >= MODULUS
  - t = t + (b[i] ? a : 0), minus MODULUS if the sum >= MODULUS
  - acc = t
  - after i==0, go to FIN (WIDTH cycles in MUL)
- FIN (1 cycle): result = acc + c, minus MODULUS if >= MODULUS; zero updated; overflow=0; state -> DONE.
- muladdmod latency: out_valid asserts WIDTH+2 cycles after the accept edge.
- Intermediate widths are WIDTH+1 bits; no truncation before comparison.
- DONE: out_valid=1. result/zero/overflow held stable while out_ready=0.
- DONE with out_ready=1 at an edge: out_valid -> 0, state -> IDLE. result/zero/overflow keep their last values.
- Throughput: at most one op per 2 cycles (single-cycle ops, out_ready high).
- in_valid while not in IDLE is ignored; the upstream holds the request.
- aluctl/a/b/c changes after accept have no effect on the op in progress.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> out_valid=0, result=0, in_ready=1 immediately. Release, then add a=3 b=4 -> result=7, zero=0, out_valid exactly 1 cycle after accept.
- Arithmetic flags:
  - add a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1.
  - sub a=5 b=7 -> 0xFFFFFFFE, overflow=0.
  - sub a=9 b=9 -> zero=1.
- Logic ops, a=0xFFFFFFFF b=1:
  - slt -> 1.
  - double xor a=0xF0F0F0F0 b=0x0FF00FF0 c=0x00000001 -> 0xFF00FF01.
  - andor a=0xFF00 b=0x0F0F c=0x1 -> 0x0F01.
  - nor 0,0 -> 0xFFFFFFFF.
  - code 15 -> 0, zero=1.
- muladdmod, MODULUS=65521: a=1000 b=70000 c=5 -> result 23577, out_valid exactly 34 cycles after accept, in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored. Raise out_ready -> one transfer, then next op accepted.
- Reset during MUL (cycle 10): state IDLE, out_valid never pulses. A following muladdmod a=2 b=3 c=65520 -> result 5.
